// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package irq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      PENDING,
      WAIT_FIN,
      ACK
   } irq_state_t;

   localparam logic [31:0] MCAUSE_IRQ_BASE = 32'h8000_0010;
   localparam int          IRQ_NUM_MAX     = 16;

   // Index width for a line count; a single line still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral/core/CSR signal bundle of the interrupt controller.
interface irq_controller_if #(
   parameter int IRQ_NUM = 16
);
   logic [31:0]        mie_i;
   logic [IRQ_NUM-1:0] int_req_i;
   logic               int_fin_i;
   logic               int_o;
   logic [31:0]        mcause_o;
   logic [IRQ_NUM-1:0] int_ack_o;
   logic               busy_o;

   modport slave (
      input  mie_i, int_req_i, int_fin_i,
      output int_o, mcause_o, int_ack_o, busy_o
   );

   modport master (
      output mie_i, int_req_i, int_fin_i,
      input  int_o, mcause_o, int_ack_o, busy_o
   );
endinterface

// File: rtl/irq_controller_scan_cnt.sv
// Wrap-around scan index counter: load takes priority over enable.
module irq_scan_cnt #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load,
   input  logic [W-1:0] start,
   input  logic         en,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= start;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt source: masks, scans, traps, waits for mret, acks.
// Build option: define IRQ_ROUND_ROBIN_EN to start each scan after the last serviced line.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | no request in flight, waiting for any masked line
//   SCAN     | checking one line per cycle from the start index
//   PENDING  | one-cycle trap request with mcause valid
//   WAIT_FIN | trap taken, waiting for mret from the core
//   ACK      | one-cycle acknowledge to the serviced line
module irq_controller
   import irq_pkg::*;
#(
   parameter int IRQ_NUM = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   irq_controller_if.slave  bus
);

   localparam int           W    = idx_width(IRQ_NUM);
   localparam logic [W-1:0] LAST = W'(IRQ_NUM - 1);

   irq_state_t         state;
   logic [IRQ_NUM-1:0] masked;
   logic [W-1:0]       cnt;
   logic [W-1:0]       sel_idx;
   logic [W-1:0]       last_idx;
   logic [W-1:0]       start_idx;
   logic               hit;
   logic               cnt_load;
   logic               cnt_en;

   assign masked = bus.int_req_i & bus.mie_i[IRQ_NUM-1:0];
   assign hit    = masked[cnt];

`ifdef IRQ_ROUND_ROBIN_EN
   assign start_idx = (last_idx == LAST) ? '0 : last_idx + W'(1);
`else
   assign start_idx = '0;
   logic unused_last_idx;
   assign unused_last_idx = ^last_idx;
`endif

   if (IRQ_NUM < 32) begin : g_mie_upper
      logic unused_mie;
      assign unused_mie = ^bus.mie_i[31:IRQ_NUM];
   end

   // A scan cycle that finds no masked line at all leaves the counter alone.
   assign cnt_load = (state == IDLE) && (|masked);
   assign cnt_en   = (state == SCAN) && (|masked) && !hit;

   irq_scan_cnt #(
      .N (IRQ_NUM),
      .W (W)
   ) u_scan_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .load  (cnt_load),
      .start (start_idx),
      .en    (cnt_en),
      .cnt   (cnt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         sel_idx       <= '0;
         last_idx      <= LAST;
         bus.int_o     <= 1'b0;
         bus.mcause_o  <= '0;
         bus.int_ack_o <= '0;
         bus.busy_o    <= 1'b0;
      end else begin
         bus.int_o     <= 1'b0;
         bus.int_ack_o <= '0;
         case (state)
            IDLE: begin
               if (|masked) begin
                  state      <= SCAN;
                  bus.busy_o <= 1'b1;
               end
            end
            SCAN: begin
               if (!(|masked)) begin
                  state      <= IDLE;
                  bus.busy_o <= 1'b0;
               end else if (hit) begin
                  sel_idx      <= cnt;
                  state        <= PENDING;
                  bus.int_o    <= 1'b1;
                  bus.mcause_o <= MCAUSE_IRQ_BASE + 32'(cnt);
               end
            end
            PENDING: begin
               state <= WAIT_FIN;
            end
            WAIT_FIN: begin
               if (bus.int_fin_i) begin
                  state         <= ACK;
                  bus.int_ack_o <= IRQ_NUM'(1) << sel_idx;
               end
            end
            ACK: begin
               last_idx   <= sel_idx;
               state      <= IDLE;
               bus.busy_o <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               bus.busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
